lifm_feeder: RTL

Upstream stage of the redundancy controller. Accepts LIFM columns, each tagged with its kernel-element index, over a valid/ready stream and buffers them in a small column FIFO. Assembles them into partitions of up to `rsiz` columns and replays each partition to the controller as a gap-free burst. It then holds the next partition until the controller signals completion.

---
 rtl/lifm_feeder_pkg.sv | 29 ++
 rtl/lifm_feeder_if.sv | 33 +++
 rtl/lifm_col_fifo.sv | 87 ++++++++
 rtl/lifm_feeder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lifm_feeder_pkg.sv
// -----------------------------------------------------------------------------
// lifm_pkg
// Shared types and constants for the LIFM feeder: data widths, default FIFO
// and partition sizes, the feeder FSM state encoding and the column FIFO
// entry layout {kidx, column, last}.
// -----------------------------------------------------------------------------
package lifm_pkg;

    localparam int WORD_WIDTH        = 8;     // activation element / kernel index width
    localparam int STEP_RANGE        = 128;   // elements per LIFM column
    localparam int COL_WIDTH         = WORD_WIDTH * STEP_RANGE;
    localparam int RSIZ_WIDTH        = 2;     // partition size field width
    localparam int DEF_MAX_LIFM_RSIZ = 3;     // default max columns per partition
    localparam int DEF_FIFO_DEPTH    = 4;     // default column FIFO depth

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_BURST = 2'd2,
        ST_WAIT  = 2'd3
    } feeder_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] kidx;
        logic [COL_WIDTH-1:0]  column;
        logic                  last;
    } col_entry_t;

endpackage

// File: rtl/lifm_feeder_if.sv
// -----------------------------------------------------------------------------
// lifm_feeder_if
// Bundles the column input stream (valid/ready + kidx/column/last) and the
// controller-side bus (enable, kidx, column, rsiz, completion strobe).
//   master : upstream producer + controller side (drives in_*, rc_valid)
//   slave  : the feeder (drives in_ready and rc_* outputs)
// -----------------------------------------------------------------------------
interface lifm_feeder_if;
    import lifm_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_kidx;
    logic [COL_WIDTH-1:0]  in_column;
    logic                  in_last;

    logic                  rc_enable_in;
    logic [WORD_WIDTH-1:0] rc_kidx;
    logic [COL_WIDTH-1:0]  rc_lifm_column;
    logic [RSIZ_WIDTH-1:0] rc_rsiz;
    logic                  rc_valid;

    modport master (
        output in_valid, in_kidx, in_column, in_last, rc_valid,
        input  in_ready, rc_enable_in, rc_kidx, rc_lifm_column, rc_rsiz
    );

    modport slave (
        input  in_valid, in_kidx, in_column, in_last, rc_valid,
        output in_ready, rc_enable_in, rc_kidx, rc_lifm_column, rc_rsiz
    );

endinterface

// File: rtl/lifm_col_fifo.sv
// -----------------------------------------------------------------------------
// lifm_col_fifo
// Synchronous column FIFO with occupancy count and a peek of the `last` flag
// of the first PEEK entries (head first), used to size the next partition.
// Ports:
//   clk, srst      clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i  write one entry
//   pop_i          drop the head entry (caller guarantees non-empty)
//   head_o         current head entry (combinational from storage)
//   count_o        number of resident entries
//   last_peek_o    last flags of entries head+0 .. head+PEEK-1 (only the
//                  first count_o bits are meaningful)
// -----------------------------------------------------------------------------
module lifm_col_fifo
    import lifm_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int PEEK  = DEF_MAX_LIFM_RSIZ,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  col_entry_t       push_data_i,
    input  logic             pop_i,
    output col_entry_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [PEEK-1:0]  last_peek_o
);

    col_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset: occupancy is tracked by the pointers/count only.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Peek index wraps manually so non-power-of-two depths also work.
    genvar gi;
    generate
        for (gi = 0; gi < PEEK; gi++) begin : g_peek
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] idx;
            assign sum = {1'b0, rd_ptr_q} + (PTR_W+1)'(gi);
            assign idx = (sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(sum - (PTR_W+1)'(DEPTH))
                                                     : PTR_W'(sum);
            assign last_peek_o[gi] = mem_q[idx].last;
        end
    endgenerate

endmodule

// File: rtl/lifm_feeder.sv
// -----------------------------------------------------------------------------
// lifm_feeder
// Buffers tagged LIFM columns in a small FIFO, groups them into partitions of
// up to cfg_rsiz columns (cut short by an in_last column) and replays each
// partition to the redundancy controller as ARM + gap-free BURST, then waits
// in WAIT for rc_valid before starting the next partition.
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous reset, ACTIVE HIGH despite the name
//   cfg_rsiz    requested partition size (0 behaves as 1, clamped to max)
//   bus         lifm_feeder_if.slave: input stream + controller bus
//   busy        FSM not idle or FIFO non-empty
//   part_count  partitions issued, wraps at 2^16
// Optional feature: define LIFM_FEEDER_ZSKIP_EN to drop accepted all-zero
// columns that do not carry in_last (in_ready is not affected).
// -----------------------------------------------------------------------------
module lifm_feeder
    import lifm_pkg::*;
#(
    parameter  int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter  int MAX_LIFM_RSIZ = DEF_MAX_LIFM_RSIZ,
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [RSIZ_WIDTH-1:0] cfg_rsiz,
    lifm_feeder_if.slave          bus,
    output logic                  busy,
    output logic [15:0]           part_count
);

    feeder_state_e         state_q, state_d;
    logic [RSIZ_WIDTH-1:0] rsiz_q, rsiz_d;
    logic [RSIZ_WIDTH-1:0] beat_q, beat_d;
    logic [15:0]           part_q, part_d;
    logic                  rc_en_q;

    logic                     in_ready;
    logic                     push_en;
    logic                     pop;
    col_entry_t               push_entry;
    col_entry_t               head;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         cnt_ext;
    logic [MAX_LIFM_RSIZ-1:0] last_peek;
    logic [MAX_LIFM_RSIZ-1:0] last_ext;
    logic [RSIZ_WIDTH-1:0]    eff;
    logic [RSIZ_WIDTH-1:0]    part_size;

    // Full stays not-ready even if a pop happens this cycle (no bypass).
    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

`ifdef LIFM_FEEDER_ZSKIP_EN
    assign push_en = bus.in_valid && in_ready && !((~|bus.in_column) && !bus.in_last);
`else
    assign push_en = bus.in_valid && in_ready;
`endif

    assign push_entry = '{kidx: bus.in_kidx, column: bus.in_column, last: bus.in_last};

    lifm_col_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PEEK  (MAX_LIFM_RSIZ)
    ) u_fifo (
        .clk         (clk),
        .srst        (reset_n),
        .push_i      (push_en),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .last_peek_o (last_peek)
    );

    always_comb begin
        eff = cfg_rsiz;
        if (cfg_rsiz == '0) begin
            eff = RSIZ_WIDTH'(1);
        end else if (cfg_rsiz > RSIZ_WIDTH'(MAX_LIFM_RSIZ)) begin
            eff = RSIZ_WIDTH'(MAX_LIFM_RSIZ);
        end
    end

    // Look-ahead view of the FIFO including this cycle's push, so IDLE can
    // move to ARM on the same edge that stores the completing column.
    assign cnt_ext = fifo_count + CNT_W'(push_en);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LIFM_RSIZ; gi++) begin : g_last_ext
            assign last_ext[gi] = (CNT_W'(gi) < fifo_count) ? last_peek[gi]
                                : ((CNT_W'(gi) == fifo_count) && push_en && bus.in_last);
        end
    endgenerate

    // Descending scan: the lowest-positioned last flag wins.
    always_comb begin
        part_size = eff;
        for (int i = MAX_LIFM_RSIZ - 1; i >= 0; i--) begin
            if ((RSIZ_WIDTH'(i) < eff) && last_ext[i]) begin
                part_size = RSIZ_WIDTH'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rsiz_d  = rsiz_q;
        beat_d  = beat_q;
        part_d  = part_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_ext >= CNT_W'(part_size)) begin
                    state_d = ST_ARM;
                    rsiz_d  = part_size;
                end
            end
            ST_ARM: begin
                state_d = ST_BURST;
                beat_d  = '0;
            end
            ST_BURST: begin
                pop    = 1'b1;
                beat_d = beat_q + RSIZ_WIDTH'(1);
                if (beat_q == rsiz_q - RSIZ_WIDTH'(1)) begin
                    state_d = ST_WAIT;
                    part_d  = part_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (bus.rc_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            rsiz_q  <= '0;
            beat_q  <= '0;
            part_q  <= '0;
            rc_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rsiz_q  <= rsiz_d;
            beat_q  <= beat_d;
            part_q  <= part_d;
            rc_en_q <= (state_d == ST_ARM) || (state_d == ST_BURST);
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.rc_enable_in   = rc_en_q;
    assign bus.rc_rsiz        = rsiz_q;
    assign bus.rc_kidx        = (state_q == ST_BURST) ? head.kidx   : '0;
    assign bus.rc_lifm_column = (state_q == ST_BURST) ? head.column : '0;
    assign busy               = (state_q != ST_IDLE) || (fifo_count != '0);
    assign part_count         = part_q;

endmodule
